mux_key: RTL and testbench
==========================

MUX_KEY -- requirements
Module: mux_key

Interface
REQ-001 SHALL have parameter NR_KEY, default 2: number of key/data entries in the lookup table, minimum 1.
REQ-002 SHALL have parameter KEY_LEN, default 1: key width in bits, minimum 1.
REQ-003 SHALL have parameter DATA_LEN, default 1: data width in bits, minimum 1.
REQ-004 SHALL have port i_clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port key, input, KEY_LEN bits: select key.
REQ-007 SHALL have port lut, input, NR_KEY*(KEY_LEN+DATA_LEN) bits: packed key/data table.
REQ-008 SHALL have port default_out, input, DATA_LEN bits: value driven when no entry matches.
REQ-009 SHALL have port out, output, DATA_LEN bits: combinational selected data.
REQ-010 SHALL have port hit, output, 1 bit: combinational flag, set when at least one entry matches.
REQ-011 SHALL have port out_q, output, DATA_LEN bits: registered copy of out.
REQ-012 SHALL have port hit_q, output, 1 bit: registered copy of hit.

Function
REQ-013 SHALL pack lut so that entry i (i=0..NR_KEY-1) occupies bits [(i+1)*W-1 : i*W], where W=KEY_LEN+DATA_LEN.
REQ-014 SHALL place the key of each entry in its upper KEY_LEN bits and the data in its lower DATA_LEN bits.
REQ-015 SHALL follow from this packing that, in a concatenation {k_(N-1), d_(N-1), ..., k_0, d_0}, the first-written pair is entry NR_KEY-1.
REQ-016 SHALL mark entry i as matching when its key equals key bit-exactly.
REQ-017 SHALL compute out purely combinationally, with zero latency, as the bitwise OR of the data of all matching entries.
REQ-018 SHALL treat a single match as that entry's data, and multiple matches as the OR of their data; the order of entries SHALL NOT matter.
REQ-019 SHALL drive out = default_out and hit = 0 when no entry matches.
REQ-020 SHALL drive hit = 1 when one or more entries match; default_out SHALL then be ignored.
REQ-021 SHALL propagate any change on key, lut or default_out to out and hit in the same delta cycle, with no clock dependency.
REQ-022 SHALL, on each rising i_clk edge with i_rst=1, load out_q <= out and hit_q <= hit; out_q and hit_q therefore lag by exactly one cycle.
REQ-023 SHALL contain no internal state other than out_q and hit_q.
REQ-024 SHALL have out and hit independent of i_clk and i_rst; the combinational path SHALL stay valid during reset.
REQ-025 SHALL be fully parameterised, with no width truncation; KEY_LEN=1, DATA_LEN=1 and NR_KEY=1 SHALL all be legal.
REQ-026 SHALL treat X/Z on key as a non-match in simulation; this is not required to be synthesizable behaviour.

Reset
REQ-027 SHALL, on a rising i_clk edge with i_rst=0, set out_q=0 and hit_q=0.
REQ-028 SHALL take precedence for reset over the load in REQ-022 on the same edge.
REQ-029 SHALL resume loading out_q/hit_q on the first rising edge after i_rst returns to 1.
REQ-030 SHALL perform no asynchronous clearing: asserting i_rst between edges SHALL NOT change out_q/hit_q until the next rising edge.

Verification
REQ-031 SHALL cover, with NR_KEY=8, KEY_LEN=3, DATA_LEN=64, entry k = (k, D<<(8k)), D=0x1122334455667788:
- key=3 -> out=0x4455667788000000, hit=1;
- key=0 -> out=0x1122334455667788;
- key=7 -> out=0x8800000000000000.
REQ-032 SHALL cover no-match: NR_KEY=2, KEY_LEN=2, entries keys 0,1, default_out=0xA5, key=3 -> out=0xA5, hit=0.
REQ-033 SHALL cover duplicate keys: two entries with key=2 and data 0x0F and 0xF0, key=2 -> out=0xFF, hit=1.
REQ-034 SHALL cover registered path: change key at cycle n -> out changes immediately, and out_q/hit_q equal the new value after edge n+1.
REQ-035 SHALL cover reset: hold i_rst=0 for 2 edges with a matching key -> out_q=0 and hit_q=0 while out stays valid; release -> out_q=out after the next edge.
REQ-036 SHALL cover minimal configuration: NR_KEY=1, KEY_LEN=1, DATA_LEN=1, entry (1,1), sweep key 0/1 with default_out=0 -> out=0/1.

Source files
------------

// File: rtl/mux_key.sv
// mux_key: keyed lookup multiplexer over a packed key/data table.
//
// The table `lut` holds NR_KEY entries. Entry i sits at bits [(i+1)*W-1 : i*W] with
// W = KEY_LEN + DATA_LEN. Its key is in the upper KEY_LEN bits and its data in the
// lower DATA_LEN bits. Every entry whose key equals `key` contributes its data to `out`
// by bitwise OR. When no entry matches, `out` takes `default_out`.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active-low (clears out_q/hit_q only)
//   key          select key, KEY_LEN bits
//   lut          packed key/data table, NR_KEY*(KEY_LEN+DATA_LEN) bits
//   default_out  value driven on `out` when nothing matches
//   out          combinational selected data (OR of all matching entries)
//   hit          combinational, set when at least one entry matches
//   out_q        `out` registered one cycle later
//   hit_q        `hit` registered one cycle later
module mux_key #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [KEY_LEN-1:0]                      key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]    lut,
  input  logic [DATA_LEN-1:0]                     default_out,
  output logic [DATA_LEN-1:0]                     out,
  output logic                                    hit,
  output logic [DATA_LEN-1:0]                     out_q,
  output logic                                    hit_q
);

  localparam int unsigned EntryW = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  entry_key  [NR_KEY];
  logic [DATA_LEN-1:0] entry_data [NR_KEY];
  logic [NR_KEY-1:0]   match;
  logic [DATA_LEN-1:0] match_data;

  // Unpack the flat table into per-entry key and data fields.
  always_comb begin
    for (int i = 0; i < int'(NR_KEY); i++) begin
      entry_data[i] = lut[i*EntryW +: DATA_LEN];
      entry_key[i]  = lut[i*EntryW + DATA_LEN +: KEY_LEN];
    end
  end

  // An unknown compare result takes the else path. X/Z on `key` therefore reads
  // as a non-match in simulation. Synthesis sees a plain equality.
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(NR_KEY); i++) begin
      if (entry_key[i] == key) begin
        match[i] = 1'b1;
      end else begin
        match[i] = 1'b0;
      end
    end
  end

  // OR of all matching data. Entry order is irrelevant and duplicates merge.
  always_comb begin
    match_data = '0;
    for (int i = 0; i < int'(NR_KEY); i++) begin
      if (match[i]) begin
        match_data = match_data | entry_data[i];
      end
    end
  end

  always_comb begin
    hit = |match;
    out = hit ? match_data : default_out;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else begin
      out_q <= out;
      hit_q <= hit;
    end
  end

endmodule

// File: tb/tb_mux_key.sv
module tb_mux_key;

  // Three instances: wide (8x3x64), narrow (2x2x8), minimal (1x1x1).
  logic         clk;
  logic         rst;

  logic [2:0]   key_a;
  logic [535:0] lut_a;
  logic [63:0]  def_a, out_a, out_q_a;
  logic         hit_a, hit_q_a;

  logic [1:0]   key_b;
  logic [19:0]  lut_b;
  logic [7:0]   def_b, out_b, out_q_b;
  logic         hit_b, hit_q_b;

  logic         key_c;
  logic [1:0]   lut_c;
  logic         def_c, out_c, out_q_c;
  logic         hit_c, hit_q_c;

  int unsigned n_cmp;
  int unsigned n_err;

  // Reference state: per config c, entry keys, data, selected key, default value.
  int unsigned kk   [3][8];
  logic [63:0] dd   [3][8];
  int unsigned sel  [3];
  logic [63:0] dflt [3];

  mux_key #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(64)) u_a (
    .i_clk(clk), .i_rst(rst), .key(key_a), .lut(lut_a), .default_out(def_a),
    .out(out_a), .hit(hit_a), .out_q(out_q_a), .hit_q(hit_q_a)
  );

  mux_key #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(8)) u_b (
    .i_clk(clk), .i_rst(rst), .key(key_b), .lut(lut_b), .default_out(def_b),
    .out(out_b), .hit(hit_b), .out_q(out_q_b), .hit_q(hit_q_b)
  );

  mux_key #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) u_c (
    .i_clk(clk), .i_rst(rst), .key(key_c), .lut(lut_c), .default_out(def_c),
    .out(out_c), .hit(hit_c), .out_q(out_q_c), .hit_q(hit_q_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Collect the data of every matching entry, then OR-reduce the collection.
  function automatic void model(input int c, output logic [63:0] o, output logic h);
    logic [63:0] found[$];
    int nr;
    nr = (c == 0) ? 8 : ((c == 1) ? 2 : 1);
    for (int i = 0; i < nr; i++) begin
      if (kk[c][i] == sel[c]) found.push_back(dd[c][i]);
    end
    h = (found.size() != 0);
    o = h ? found.or() : dflt[c];
  endfunction

  // Build each lut as the concatenation {k_(N-1), d_(N-1), ..., k_0, d_0}.
  task automatic apply();
    lut_a = '0;
    for (int i = 7; i >= 0; i--) lut_a = (lut_a << 67) | 536'({3'(kk[0][i]), dd[0][i]});
    lut_b = '0;
    for (int i = 1; i >= 0; i--) lut_b = (lut_b << 10) | 20'({2'(kk[1][i]), dd[1][i][7:0]});
    lut_c = {kk[2][0][0], dd[2][0][0]};
    key_a = 3'(sel[0]);
    def_a = dflt[0];
    key_b = 2'(sel[1]);
    def_b = dflt[1][7:0];
    key_c = sel[2][0];
    def_c = dflt[2][0];
  endtask

  // Drive inputs, check the combinational outputs, clock once, check the registers.
  task automatic cycle(input string tag);
    logic [63:0] eo [3];
    logic        eh [3];
    logic        rst_edge;
    apply();
    #1;
    for (int c = 0; c < 3; c++) model(c, eo[c], eh[c]);
    check({tag, "_a_out"}, out_a, eo[0]);
    check({tag, "_a_hit"}, 64'(hit_a), 64'(eh[0]));
    check({tag, "_b_out"}, 64'(out_b), eo[1]);
    check({tag, "_b_hit"}, 64'(hit_b), 64'(eh[1]));
    check({tag, "_c_out"}, 64'(out_c), eo[2]);
    check({tag, "_c_hit"}, 64'(hit_c), 64'(eh[2]));
    rst_edge = rst;
    @(posedge clk);
    #1;
    if (!rst_edge) begin
      for (int c = 0; c < 3; c++) begin
        eo[c] = '0;
        eh[c] = 1'b0;
      end
    end
    check({tag, "_a_out_q"}, out_q_a, eo[0]);
    check({tag, "_a_hit_q"}, 64'(hit_q_a), 64'(eh[0]));
    check({tag, "_b_out_q"}, 64'(out_q_b), eo[1]);
    check({tag, "_b_hit_q"}, 64'(hit_q_b), 64'(eh[1]));
    check({tag, "_c_out_q"}, 64'(out_q_c), eo[2]);
    check({tag, "_c_hit_q"}, 64'(hit_q_c), 64'(eh[2]));
    @(negedge clk);
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < 8; i++) begin
      kk[0][i] = $urandom_range(7);
      dd[0][i] = {$urandom, $urandom};
    end
    sel[0]  = $urandom_range(7);
    dflt[0] = {$urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      kk[1][i] = $urandom_range(3);
      dd[1][i] = 64'($urandom_range(255));
    end
    sel[1]   = $urandom_range(3);
    dflt[1]  = 64'($urandom_range(255));
    kk[2][0] = $urandom_range(1);
    dd[2][0] = 64'($urandom_range(1));
    sel[2]   = $urandom_range(1);
    dflt[2]  = 64'($urandom_range(1));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) begin
        kk[c][i] = 0;
        dd[c][i] = '0;
      end
    end
    // Wide table: entry k = (k, D << 8k).
    for (int k = 0; k < 8; k++) begin
      kk[0][k] = k;
      dd[0][k] = 64'h1122334455667788 << (8 * k);
    end
    dflt[0] = 64'hDEAD_BEEF_0000_0001;
    // Narrow table: keys 0 and 1, default 0xA5, key 3 misses.
    kk[1][0] = 0; dd[1][0] = 64'h3C;
    kk[1][1] = 1; dd[1][1] = 64'h5A;
    sel[1]   = 3; dflt[1]  = 64'hA5;
    // Minimal table: entry (1,1), default 0.
    kk[2][0] = 1; dd[2][0] = 64'h1; dflt[2] = '0; sel[2] = 0;
    sel[0] = 3;

    @(negedge clk);
    cycle("rst0");
    cycle("rst1");
    rst = 1'b1;

    sel[0] = 3; sel[2] = 0;
    cycle("k3");
    check("a_k3_const", out_a, 64'h4455667788000000);
    check("a_k3_hit", 64'(hit_a), 64'h1);
    check("b_nomatch_const", 64'(out_b), 64'hA5);
    check("b_nomatch_hit", 64'(hit_b), 64'h0);
    check("c_k0_const", 64'(out_c), 64'h0);

    // Reset asserted between edges must leave the registers alone until the edge.
    rst = 1'b0;
    #2;
    check("async_a_out_q", out_q_a, 64'h4455667788000000);
    check("async_a_hit_q", 64'(hit_q_a), 64'h1);
    #3;
    cycle("hold0");
    cycle("hold1");
    check("hold_a_out_valid", out_a, 64'h4455667788000000);
    rst = 1'b1;
    cycle("release");
    check("release_a_out_q", out_q_a, 64'h4455667788000000);

    sel[0] = 0; sel[2] = 1;
    cycle("k0");
    check("a_k0_const", out_a, 64'h1122334455667788);
    check("c_k1_const", 64'(out_c), 64'h1);
    check("c_k1_hit", 64'(hit_c), 64'h1);

    sel[0] = 7;
    kk[1][0] = 2; dd[1][0] = 64'h0F;
    kk[1][1] = 2; dd[1][1] = 64'hF0;
    sel[1]   = 2;
    cycle("k7_dup");
    check("a_k7_const", out_a, 64'h8800000000000000);
    check("b_dup_const", 64'(out_b), 64'hFF);
    check("b_dup_hit", 64'(hit_b), 64'h1);

    for (int n = 0; n < 400; n++) begin
      rand_cfg();
      rst = ($urandom_range(15) != 0);
      cycle($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
